mul_share_arbiter: RTL and testbench

- Shares one 4x4 signed combinational multiplier (`comb_multiplier`) between NUM_REQ independent requesters.
- Round-robin arbitration on the inputs; one registered result slot on the output.
- Valid/ready handshakes on both sides; each result carries the ID of its requester.
- Sits between CPU-side micro-sequencers and the multiplier datapath, so there is one multiplier instance instead of one per client.

---
 rtl/mul_arb_pkg.sv | 15 +
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/comb_multiplier.sv | 10 +
 rtl/rr_pick.sv | 28 ++
 rtl/mul_share_arbiter.sv | 90 +++++++++
 tb/tb_mul_share_arbiter.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types for the shared-multiplier arbiter: operand/result widths and slot states.
package mul_arb_pkg;

    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned RESULT_W  = 8;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic signed [RESULT_W-1:0]  result_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester and response handshake bundle for mul_share_arbiter.
interface mul_share_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] req_a;
    logic [NUM_REQ-1:0][OPERAND_W-1:0] req_b;
    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [RESULT_W-1:0]               rsp_result;
    logic [ID_W-1:0]                   rsp_id;
    logic [CNT_W-1:0]                  op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id, op_count
    );
endinterface

// File: rtl/comb_multiplier.sv
// 4x4 signed combinational multiplier; operands sign-extended to the 8-bit product width.
module comb_multiplier
    import mul_arb_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output result_t  p
);
    assign p = RESULT_W'(a) * RESULT_W'(b);
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx,
    output logic          any
);
    int unsigned k;

    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!any && req[IW'(k)]) begin
                any              = 1'b1;
                gidx             = IW'(k);
                grant[IW'(k)]    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one signed 4x4 multiplier among NUM_REQ requesters,
// with a single registered result slot tagged by requester ID.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic                clk,
    input logic                arst_n,
    mul_share_arbiter_if.slave bus
);
    slot_state_e        state_q, state_d;
    result_t            result_q, result_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               any;
    logic               can_accept;
    logic               xfer;
    operand_t           op_a, op_b;
    result_t            product;

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    assign op_a = bus.req_a[gidx];
    assign op_b = bus.req_b[gidx];

    comb_multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Slot may refill in the same cycle it drains.
    assign can_accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
    assign xfer       = can_accept && any;

    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        id_d          = id_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        bus.req_ready = '0;
        if (xfer && arst_n) begin
            bus.req_ready = grant;
        end
        if (xfer) begin
            state_d  = SLOT_FULL;
            result_d = product;
            id_d     = gidx;
            ptr_d    = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
            count_d  = count_q + CNT_W'(1);
        end else if (bus.rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= SLOT_EMPTY;
            result_q <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.rsp_valid  = (state_q == SLOT_FULL);
    assign bus.rsp_result = result_q;
    assign bus.rsp_id     = id_q;
    assign bus.op_count   = count_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with hand-computed products and grant order.
module tb_mul_share_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 16;

    logic clk;
    logic arst_n;
    int   n_checks;
    int   n_fail;

    mul_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] res, input logic [1:0] id,
                              input logic [15:0] cnt);
        check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".result"}, 32'(bus.rsp_result), 32'(res));
        check({tag, ".id"}, 32'(bus.rsp_id), 32'(id));
        check({tag, ".count"}, 32'(bus.op_count), 32'(cnt));
    endtask

    localparam logic [7:0] FAIR_RES [4] = '{8'hFE, 8'hFC, 8'hFA, 8'hF8};

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        arst_n        = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, req_ready forced low even with all requesters valid
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.result", 32'(bus.rsp_result), 32'd0);
        check("rst.id", 32'(bus.rsp_id), 32'd0);
        check("rst.count", 32'(bus.op_count), 32'd0);
        check("rst.ready", 32'(bus.req_ready), 32'd0);

        // Single requester 0: 3*5
        arst_n        = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_a[0]  = 4'd3;
        bus.req_b[0]  = 4'd5;
        #1 check("single.ready", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        expect_rsp("single", 8'h0F, 2'd0, 16'd1);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("drain.valid", 32'(bus.rsp_valid), 32'd0);

        // Signed products through requester 2
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 4'hD;
        bus.req_b[2]  = 4'h5;
        #1 check("neg.ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        expect_rsp("neg", 8'hF1, 2'd2, 16'd2);
        bus.req_a[2] = 4'h8;
        bus.req_b[2] = 4'h8;
        @(negedge clk);
        expect_rsp("minmin", 8'h40, 2'd2, 16'd3);
        bus.req_a[2] = 4'h7;
        bus.req_b[2] = 4'h8;
        @(negedge clk);
        expect_rsp("maxmin", 8'hC8, 2'd2, 16'd4);
        bus.req_valid = 4'b1000;
        bus.req_a[3]  = 4'hF;
        bus.req_b[3]  = 4'hF;
        @(negedge clk);
        expect_rsp("m1m1", 8'h01, 2'd3, 16'd5);

        // Fairness: all valid, pointer now 0
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i] = 4'(i + 1);
            bus.req_b[i] = 4'hE;
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expect_rsp($sformatf("fair%0d", k), FAIR_RES[k % 4], 2'(k % 4), 16'(6 + k));
        end

        // Backpressure: slot full, consumer stalled
        bus.rsp_ready = 1'b0;
        #1 check("bp.ready0", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d.ready", k), 32'(bus.req_ready), 32'd0);
            expect_rsp($sformatf("bp%0d", k), 8'hFC, 2'd1, 16'd11);
        end
        bus.rsp_ready = 1'b1;
        #1 check("bp.release_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        expect_rsp("bp.refill", 8'hFA, 2'd2, 16'd12);

        // Pointer hold across idle cycles
        bus.req_valid = 4'b0010;
        #1 check("hold.ready1", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        expect_rsp("hold.g1", 8'hFC, 2'd1, 16'd13);
        bus.req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        check("hold.idle_valid", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 4'b0101;
        #1 check("hold.ready2", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        expect_rsp("hold.g2", 8'hFA, 2'd2, 16'd14);
        check("hold.ready0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        expect_rsp("hold.g0", 8'hFE, 2'd0, 16'd15);

        // Reset while a result is held under backpressure
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        expect_rsp("mid.full", 8'hFE, 2'd0, 16'd15);
        arst_n = 1'b0;
        #1;
        check("mid.valid", 32'(bus.rsp_valid), 32'd0);
        check("mid.count", 32'(bus.op_count), 32'd0);
        check("mid.ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        arst_n        = 1'b1;
        bus.req_valid = 4'b1010;
        bus.rsp_ready = 1'b1;
        #1 check("post.ready", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        expect_rsp("post", 8'hFC, 2'd1, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
